bow_rx_deframer: RTL and testbench



---
 rtl/bow_pkg.sv | 22 ++
 rtl/bow_prbs_chk.sv | 33 +++
 rtl/bow_rx_deframer.sv | 132 +++++++++++++
 tb/tb_bow_rx_deframer.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bow_pkg.sv
// Shared types and constants for the BoW receive deframer.
// PRBS is a 16-bit Fibonacci LFSR shifting left, feedback into bit 0.
package bow_pkg;

  typedef enum logic [1:0] {
    TRAIN,
    WAIT,
    CAPTURE,
    DRAIN
  } state_t;

  localparam int PRBS_W = 16;
  localparam int OUT_W  = 18;
  localparam logic [PRBS_W-1:0] PRBS_TAPS = 16'hB400;

  function automatic logic [PRBS_W-1:0] prbs_next(
    input logic [PRBS_W-1:0] s
  );
    return {s[PRBS_W-2:0], ^(s & PRBS_TAPS)};
  endfunction

endpackage

// File: rtl/bow_prbs_chk.sv
// Self-synchronising PRBS checker: the last word seen is the LFSR state,
// so a mismatch automatically reseeds from the received word.
module bow_prbs_chk
  import bow_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              clr,
  input  logic [PRBS_W-1:0] data,
  output logic              hit,
  output logic              miss
);

  logic [PRBS_W-1:0] last;
  logic              seeded;
  logic              same;

  assign same = (data == prbs_next(last));
  assign hit  = en && seeded && same;
  assign miss = en && seeded && !same;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      last   <= '0;
      seeded <= 1'b0;
    end else if (en) begin
      last   <= data;
      seeded <= 1'b1;
    end
  end

endmodule

// File: rtl/bow_rx_deframer.sv
// BoW receive deframer: PRBS training/lock, one-burst capture buffer,
// and a registered valid/ready drain toward the link layer.
module bow_rx_deframer
  import bow_pkg::*;
#(
  parameter int DEPTH    = 32,
  parameter int LOCK_CNT = 8,
  parameter int ERR_W    = 8
) (
  input  logic              rxclk,
  input  logic              preset,
  input  logic [15:0]       rx_data,
  input  logic              rx_fec,
  input  logic              rx_aux,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_valid,
  output logic              out_last,
  input  logic              out_ready,
  output logic              locked,
  output logic [ERR_W-1:0]  prbs_err,
  output logic              burst_done
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(LOCK_CNT + 1);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [AW-1:0]    rnext;
  logic [OUT_W-1:0] mem [DEPTH];
  logic             hit;
  logic             miss;
  logic             wr_en;

  assign rnext = rptr + AW'(1);
  assign wr_en = rx_valid && (state == WAIT || state == CAPTURE);

  bow_prbs_chk u_chk (
    .clk  (rxclk),
    .rst  (preset),
    .en   (rx_valid && state == TRAIN),
    .clr  (state != TRAIN),
    .data (rx_data),
    .hit  (hit),
    .miss (miss)
  );

  // WAIT always writes at 0 because wptr is clear on entry
  always_ff @(posedge rxclk) begin
    if (wr_en)
      mem[wptr] <= {rx_fec, rx_aux, rx_data};
  end

  always_ff @(posedge rxclk) begin
    if (preset) begin
      state      <= TRAIN;
      cnt        <= '0;
      wptr       <= '0;
      rptr       <= '0;
      rx_ready   <= 1'b0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      out_data   <= '0;
      locked     <= 1'b0;
      prbs_err   <= '0;
      burst_done <= 1'b0;
    end else begin
      burst_done <= 1'b0;
      unique case (state)
        TRAIN: begin
          if (hit) begin
            if (cnt == CW'(LOCK_CNT - 1)) begin
              cnt      <= '0;
              locked   <= 1'b1;
              rx_ready <= 1'b1;
              state    <= WAIT;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end else if (miss) begin
            cnt    <= '0;
            locked <= 1'b0;
            if (prbs_err != '1)
              prbs_err <= prbs_err + ERR_W'(1);
          end
        end
        WAIT: begin
          if (rx_valid) begin
            wptr  <= AW'(1);
            state <= CAPTURE;
          end
        end
        CAPTURE: begin
          if (rx_valid) begin
            wptr <= wptr + AW'(1);
            if (wptr == AW'(DEPTH - 1)) begin
              rx_ready <= 1'b0;
              state    <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
            out_data  <= mem[rptr];
            out_last  <= (rptr == AW'(DEPTH - 1));
          end else if (out_ready) begin
            if (out_last) begin
              out_valid  <= 1'b0;
              out_last   <= 1'b0;
              rptr       <= '0;
              wptr       <= '0;
              cnt        <= '0;
              burst_done <= 1'b1;
              state      <= TRAIN;
            end else begin
              rptr     <= rnext;
              out_data <= mem[rnext];
              out_last <= (rnext == AW'(DEPTH - 1));
            end
          end
        end
        default: state <= TRAIN;
      endcase
    end
  end

endmodule

// File: tb/tb_bow_rx_deframer.sv
// Bench for bow_rx_deframer: queue-based burst model checked every cycle,
// plus literal expectations for lock, errors, stall, reset and saturation.
module tb_bow_rx_deframer;

  localparam int DEPTH = 32;
  localparam int LOCK  = 8;

  logic        rxclk = 1'b0;
  logic        preset = 1'b1;
  logic [15:0] rx_data = '0;
  logic        rx_fec = 1'b0;
  logic        rx_aux = 1'b0;
  logic        rx_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic        rx_ready;
  logic [17:0] out_data;
  logic        out_valid;
  logic        out_last;
  logic        locked;
  logic [7:0]  prbs_err;
  logic        burst_done;

  int checks = 0;
  int errors = 0;

  bow_rx_deframer dut (
    .rxclk      (rxclk),
    .preset     (preset),
    .rx_data    (rx_data),
    .rx_fec     (rx_fec),
    .rx_aux     (rx_aux),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_last   (out_last),
    .out_ready  (out_ready),
    .locked     (locked),
    .prbs_err   (prbs_err),
    .burst_done (burst_done)
  );

  always #5 rxclk = ~rxclk;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, got, exp);
    end
  endtask

  function automatic logic [15:0] lfsr(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  // Model: phase 0 train, 1 awaiting first word, 2 capturing, 3 draining
  int          ph = 0;
  logic [15:0] m_prev = '0;
  bit          m_seed = 0;
  int          m_cnt = 0;
  int          m_err = 0;
  bit          m_lock = 0;
  bit          m_rdy = 0;
  bit          m_done = 0;
  logic [17:0] q[$];
  int          idx = 0;
  bit          pstall = 0;
  logic [17:0] pdata = '0;

  always @(negedge rxclk) begin
    chk("locked", locked, m_lock);
    chk("rx_ready", rx_ready, m_rdy);
    chk("prbs_err", prbs_err, m_err);
    chk("burst_done", burst_done, m_done);
    if (pstall) begin
      chk("hold_valid", out_valid, 1);
      chk("hold_data", out_data, pdata);
    end
    if (out_valid) begin
      if (ph != 3 || q.size() == 0)
        chk("spurious_valid", out_valid, 0);
      else begin
        chk("out_data", out_data, q[0]);
        chk("out_last", out_last, idx == DEPTH - 1);
      end
    end
    pstall = out_valid && !out_ready && !preset;
    pdata  = out_data;
    m_done = 0;
    if (preset) begin
      ph = 0; m_seed = 0; m_cnt = 0; m_err = 0;
      m_lock = 0; m_rdy = 0; idx = 0; q.delete();
    end else begin
      case (ph)
        0: if (rx_valid) begin
          if (!m_seed) begin
            m_seed = 1;
          end else if (rx_data == lfsr(m_prev)) begin
            m_cnt++;
            if (m_cnt == LOCK) begin
              m_lock = 1; m_rdy = 1; ph = 1; m_seed = 0; m_cnt = 0;
            end
          end else begin
            m_cnt = 0; m_lock = 0;
            m_err = (m_err == 255) ? 255 : m_err + 1;
          end
          m_prev = rx_data;
        end
        1: if (rx_valid) begin
          q.push_back({rx_fec, rx_aux, rx_data});
          ph = 2;
        end
        2: if (rx_valid) begin
          q.push_back({rx_fec, rx_aux, rx_data});
          if (q.size() == DEPTH) begin
            m_rdy = 0; ph = 3; idx = 0;
          end
        end
        default: if (out_valid && out_ready && q.size() > 0) begin
          void'(q.pop_front());
          idx++;
          if (idx == DEPTH) begin
            m_done = 1; ph = 0; m_seed = 0; m_cnt = 0; idx = 0;
          end
        end
      endcase
    end
  end

  task automatic put(input bit v, input logic [15:0] d,
                     input bit f, input bit a);
    @(posedge rxclk);
    #1;
    rx_valid = v;
    rx_data  = d;
    rx_fec   = f;
    rx_aux   = a;
  endtask

  task automatic idle();
    put(0, 'x, 0, 0);
  endtask

  task automatic train_lock(input logic [15:0] seed);
    logic [15:0] w;
    w = seed;
    put(1, w, 0, 0);
    for (int i = 0; i < LOCK; i++) begin
      w = lfsr(w);
      put(1, w, 0, 0);
    end
    idle();
  endtask

  task automatic capture(input bit gaps);
    logic [15:0] a;
    for (int i = 0; i < DEPTH; i++) begin
      a = 16'(i);
      put(1, a, a[0], a[1]);
      if (gaps) idle();
    end
    idle();
  endtask

  task automatic drain(input int stall_at, input int rst_at);
    bit stalled;
    int dn;
    stalled = 0;
    dn = 0;
    out_ready = 1;
    for (int t = 0; t < 300; t++) begin
      @(posedge rxclk);
      #1;
      if (burst_done) begin
        dn++;
        break;
      end
      if (out_valid && int'(out_data[15:0]) == stall_at && !stalled) begin
        stalled = 1;
        out_ready = 0;
        repeat (3) begin
          @(posedge rxclk);
          #1;
          chk("stall_data", out_data, 18'h1000A);
        end
        out_ready = 1;
      end
      if (out_valid && int'(out_data[15:0]) == rst_at) begin
        preset = 1;
        @(posedge rxclk);
        #1;
        preset = 0;
        chk("midrst_valid", out_valid, 0);
        chk("midrst_ready", rx_ready, 0);
        chk("midrst_locked", locked, 0);
        return;
      end
    end
    chk("burst_done_once", dn, 1);
  endtask

  initial begin
    logic [15:0] w;
    repeat (3) @(posedge rxclk);
    #1;
    preset = 0;
    @(negedge rxclk);
    chk("rst_ready", rx_ready, 0);
    chk("rst_locked", locked, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_err", prbs_err, 0);

    train_lock(16'hACE1);
    @(negedge rxclk);
    chk("lock_locked", locked, 1);
    chk("lock_ready", rx_ready, 1);
    chk("lock_err", prbs_err, 0);

    capture(1);
    @(negedge rxclk);
    chk("cap_ready_low", rx_ready, 0);
    drain(10, -1);
    repeat (3) idle();
    chk("post_burst_locked", locked, 1);

    @(posedge rxclk);
    #1;
    preset = 1;
    @(posedge rxclk);
    #1;
    preset = 0;
    w = 16'hACE1;
    put(1, w, 0, 0);
    for (int i = 0; i < 5; i++) begin
      w = lfsr(w);
      put(1, w, 0, 0);
    end
    w = lfsr(w) ^ 16'h0001;
    put(1, w, 0, 0);
    for (int i = 0; i < LOCK - 1; i++) begin
      w = lfsr(w);
      put(1, w, 0, 0);
    end
    idle();
    @(negedge rxclk);
    chk("err_nolock_yet", locked, 0);
    chk("err_count", prbs_err, 1);
    w = lfsr(w);
    put(1, w, 0, 0);
    idle();
    @(negedge rxclk);
    chk("err_relock", locked, 1);

    capture(0);
    drain(-1, 20);

    for (int i = 0; i < 301; i++) put(1, 16'hFFFF, 0, 0);
    idle();
    @(negedge rxclk);
    chk("sat_err", prbs_err, 8'hFF);
    chk("sat_locked", locked, 0);

    repeat (2) @(posedge rxclk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
